// File: rtl/counter_pop.sv
// rtl/counter_pop.sv - drains a requested number of elements from a FIFO, one handshake at a time
module counter_pop #(
    parameter int NBITS_FOR_COUNTER = 3,
    parameter int DATA_WIDTH        = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NBITS_FOR_COUNTER-1:0] length,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         pop,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [NBITS_FOR_COUNTER-1:0] CNT_ONE = NBITS_FOR_COUNTER'(1);

    state_t                       state;
    logic [NBITS_FOR_COUNTER-1:0] count;
    logic [NBITS_FOR_COUNTER-1:0] len_q;

    // The read strobe must react to fifo_empty in the same cycle, so it is decoded
    // from the state register; reset suppresses it so an abort never consumes data.
    assign pop = (state == POP) && !fifo_empty && !reset;

    // Drain sequencer: one pop, one capture, one downstream handshake per element.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            len_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            len_q <= length;
                            count <= '0;
                            state <= POP;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                POP: begin
                    if (!fifo_empty) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // FIFO read data is valid the cycle after the pop strobe.
                    out_data  <= fifo_data;
                    count     <= count + CNT_ONE;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (count == len_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= POP;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
